dot_product_accumulator: RTL and testbench

Sequential multiply-accumulate stage built around the team's combinational 4-bit array multiplier, which it instantiates.
- Accepts a stream of 4-bit operand pairs over a valid/ready handshake.
- Registers each 8-bit product and sums LEN consecutive products into an accumulator.
- Presents the dot-product result on an output valid/ready handshake.
- Intended as the bridge between operand sources and downstream filter/correlator logic.

---
 rtl/dot_product_accumulator.sv | 125 ++++++++++++
 tb/tb_dot_product_accumulator.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dot_product_accumulator.sv
// rtl/dot_product_accumulator.sv - 4x4 multiply-accumulate stage producing LEN-term dot products.
// Optional build macro SATURATE_EN: clamp the accumulator to all-ones instead of wrapping.

module array_mult4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);
  // Shift-and-add array: one partial-product row per bit of b.
  always_comb begin
    p_o = '0;
    for (int i = 0; i < 4; i++) begin
      if (b_i[i]) p_o = p_o + ({4'b0, a_i} << i);
    end
  end
endmodule

module dot_product_accumulator #(
  parameter int LEN   = 4,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);
  typedef enum logic [1:0] {ACCUM, FLUSH, DONE} state_t;

  localparam logic [7:0] LAST = 8'(LEN - 1);

  state_t           state_q, state_d;
  logic [7:0]       count_q, count_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       p_q, p_d;
  logic             p_vld_q, p_vld_d;
  logic [7:0]       prod;
  logic [ACC_W:0]   sum;
  logic             accept;

  array_mult4 u_mult (
    .a_i(in_a),
    .b_i(in_b),
    .p_o(prod)
  );

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign out_sum   = out_valid ? acc_q : '0;
  assign out_ovf   = out_valid & ovf_q;
  // A beat arriving alongside clr is discarded, so it never counts as accepted.
  assign accept    = in_valid & in_ready & ~clr;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    p_d     = p_q;
    p_vld_d = 1'b0;
    sum     = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, p_q};

    if (accept) begin
      p_d     = prod;
      p_vld_d = 1'b1;
      count_d = count_q + 8'd1;
    end

    if (p_vld_q) begin
      if (sum[ACC_W]) ovf_d = 1'b1;
`ifdef SATURATE_EN
      acc_d = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
      acc_d = sum[ACC_W-1:0];
`endif
    end

    case (state_q)
      ACCUM: if (accept && count_q == LAST) state_d = FLUSH;
      FLUSH: state_d = DONE;
      DONE: begin
        if (out_ready) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          count_d = '0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase

    if (clr) begin
      acc_d   = '0;
      ovf_d   = 1'b0;
      count_d = '0;
      p_vld_d = 1'b0;
      state_d = ACCUM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      count_q <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      p_q     <= '0;
      p_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      p_q     <= p_d;
      p_vld_q <= p_vld_d;
    end
  end
endmodule

// File: tb/tb_dot_product_accumulator.sv
// tb/tb_dot_product_accumulator.sv - directed vector bench for dot_product_accumulator.
module tb_dot_product_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;
  logic out_ready = 1'b1;

  logic        d0_in_ready, d0_out_valid, d0_out_ovf;
  logic [15:0] d0_out_sum;
  logic        d1_in_ready, d1_out_valid, d1_out_ovf;
  logic [7:0]  d1_out_sum;
  logic        d2_in_ready, d2_out_valid, d2_out_ovf;
  logic [15:0] d2_out_sum;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dot_product_accumulator #(.LEN(4), .ACC_W(16)) u_d0 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(d0_in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(d0_out_valid), .out_ready(out_ready),
    .out_sum(d0_out_sum), .out_ovf(d0_out_ovf));

  dot_product_accumulator #(.LEN(2), .ACC_W(8)) u_d1 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(d1_in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(d1_out_valid), .out_ready(out_ready),
    .out_sum(d1_out_sum), .out_ovf(d1_out_ovf));

  dot_product_accumulator #(.LEN(1), .ACC_W(16)) u_d2 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(d2_in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(d2_out_valid), .out_ready(out_ready),
    .out_sum(d2_out_sum), .out_ovf(d2_out_ovf));

  typedef struct {
    logic [0:3][3:0] a;
    logic [0:3][3:0] b;
    int unsigned     exp_sum;
    int              stall;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Feeds four beats to the LEN=4 instance and follows the result through the output handshake.
  task automatic run_seq(input vec_t v);
    out_ready = (v.stall == 0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_a = v.a[i];
      in_b = v.b[i];
      chk("seq_in_ready", {31'b0, d0_in_ready}, 1);
      tick();
    end
    in_valid = 1'b0;
    chk("flush_out_valid", {31'b0, d0_out_valid}, 0);
    chk("flush_in_ready", {31'b0, d0_in_ready}, 0);
    tick();
    chk("done_out_valid", {31'b0, d0_out_valid}, 1);
    chk("done_out_sum", {16'b0, d0_out_sum}, v.exp_sum);
    chk("done_out_ovf", {31'b0, d0_out_ovf}, 0);
    chk("done_in_ready", {31'b0, d0_in_ready}, 0);
    for (int s = 0; s < v.stall; s++) begin
      tick();
      chk("stall_out_valid", {31'b0, d0_out_valid}, 1);
      chk("stall_out_sum", {16'b0, d0_out_sum}, v.exp_sum);
      chk("stall_in_ready", {31'b0, d0_in_ready}, 0);
    end
    out_ready = 1'b1;
    tick();
    chk("after_out_valid", {31'b0, d0_out_valid}, 0);
    chk("after_in_ready", {31'b0, d0_in_ready}, 1);
  endtask

  logic [0:5][3:0] la;
  logic [0:5][3:0] lb;
  logic [0:5][7:0] lp;
  vec_t ones;
  vec_t twos;

  initial begin
    vecs[0] = '{a: {4'd3, 4'd15, 4'd0, 4'd7}, b: {4'd5, 4'd15, 4'd9, 4'd2}, exp_sum: 254, stall: 0};
    vecs[1] = '{a: {4'd3, 4'd15, 4'd0, 4'd7}, b: {4'd5, 4'd15, 4'd9, 4'd2}, exp_sum: 254, stall: 5};
    vecs[2] = '{a: {4'd1, 4'd1, 4'd1, 4'd1}, b: {4'd1, 4'd1, 4'd1, 4'd1}, exp_sum: 4, stall: 0};
    vecs[3] = '{a: {4'd15, 4'd15, 4'd15, 4'd15}, b: {4'd15, 4'd15, 4'd15, 4'd15}, exp_sum: 900, stall: 0};
    vecs[4] = '{a: {4'd1, 4'd3, 4'd5, 4'd7}, b: {4'd2, 4'd4, 4'd6, 4'd8}, exp_sum: 100, stall: 2};
    ones = vecs[2];
    twos = '{a: {4'd2, 4'd2, 4'd2, 4'd2}, b: {4'd2, 4'd2, 4'd2, 4'd2}, exp_sum: 16, stall: 0};
    la = {4'd1, 4'd15, 4'd6, 4'd0, 4'd9, 4'd13};
    lb = {4'd1, 4'd15, 4'd7, 4'd5, 4'd3, 4'd11};
    lp = {8'd1, 8'd225, 8'd42, 8'd0, 8'd27, 8'd143};

    rst = 1'b1;
    tick();
    tick();
    chk("reset_in_ready", {31'b0, d0_in_ready}, 1);
    chk("reset_out_valid", {31'b0, d0_out_valid}, 0);
    chk("reset_out_sum", {16'b0, d0_out_sum}, 0);
    chk("reset_out_ovf", {31'b0, d0_out_ovf}, 0);
    rst = 1'b0;

    for (int k = 0; k < 5; k++) run_seq(vecs[k]);

    // clr alongside a valid beat drops that beat and the partial sum.
    in_valid = 1'b1; in_a = 4'd9; in_b = 4'd9;
    tick();
    tick();
    clr = 1'b1;
    chk("clr_in_ready", {31'b0, d0_in_ready}, 1);
    tick();
    clr = 1'b0;
    in_valid = 1'b0;
    chk("clr_state_ready", {31'b0, d0_in_ready}, 1);
    run_seq(twos);

    // clr in DONE discards the pending result even with out_ready high.
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 4'd5; in_b = 4'd5;
    for (int i = 0; i < 4; i++) tick();
    in_valid = 1'b0;
    tick();
    chk("pre_clr_valid", {31'b0, d0_out_valid}, 1);
    chk("pre_clr_sum", {16'b0, d0_out_sum}, 100);
    clr = 1'b1;
    out_ready = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_done_valid", {31'b0, d0_out_valid}, 0);
    chk("clr_done_ready", {31'b0, d0_in_ready}, 1);
    run_seq(ones);

    // Overflow on the 8-bit, LEN=2 instance.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 4'd15; in_b = 4'd15;
    tick();
    tick();
    in_valid = 1'b0;
    chk("ovf_flush_valid", {31'b0, d1_out_valid}, 0);
    tick();
    chk("ovf_valid", {31'b0, d1_out_valid}, 1);
`ifdef SATURATE_EN
    chk("ovf_sum", {24'b0, d1_out_sum}, 255);
`else
    chk("ovf_sum", {24'b0, d1_out_sum}, 194);
`endif
    chk("ovf_flag", {31'b0, d1_out_ovf}, 1);
    tick();
    chk("ovf_after_valid", {31'b0, d1_out_valid}, 0);
    in_valid = 1'b1; in_a = 4'd1; in_b = 4'd1;
    tick();
    tick();
    in_valid = 1'b0;
    tick();
    chk("ovf_clear_sum", {24'b0, d1_out_sum}, 2);
    chk("ovf_clear_flag", {31'b0, d1_out_ovf}, 0);

    // LEN=1 with in_valid held: one result every three cycles.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_a = la[k];
      in_b = lb[k];
      chk("len1_ready_1", {31'b0, d2_in_ready}, 1);
      tick();
      chk("len1_ready_0a", {31'b0, d2_in_ready}, 0);
      chk("len1_valid_0", {31'b0, d2_out_valid}, 0);
      tick();
      chk("len1_ready_0b", {31'b0, d2_in_ready}, 0);
      chk("len1_valid_1", {31'b0, d2_out_valid}, 1);
      chk("len1_sum", {16'b0, d2_out_sum}, {24'b0, lp[k]});
      tick();
    end
    in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
